// File: rtl/cube_edge_seq.sv
// cube_edge_seq: walks the 12 edges of a projected cube and feeds the line
// rasteriser (draw_line) one edge at a time: latch endpoints, pulse
// line_start, wait for line_done, advance. One accepted go = one frame.
// Optional feature macro: CUBE_EDGE_SHADOW_EN adds a shadow vertex bank that
// accepts writes at any time and is copied to the active bank on go.

module cube_edge_seq #(
    parameter int XY_BITW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               v_we,
    input  logic [2:0]         v_addr,
    input  logic [XY_BITW-1:0] v_x,
    input  logic [XY_BITW-1:0] v_y,
    input  logic               line_done,
    output logic               line_start,
    output logic [XY_BITW-1:0] x0,
    output logic [XY_BITW-1:0] y0,
    output logic [XY_BITW-1:0] x1,
    output logic [XY_BITW-1:0] y1,
    output logic [3:0]         edge_idx,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic       accept;
    logic       last_edge;
    logic [2:0] vert_a;
    logic [2:0] vert_b;

    logic [XY_BITW-1:0] act_x [8];
    logic [XY_BITW-1:0] act_y [8];

    assign accept    = (state == S_IDLE) && go;
    assign last_edge = (edge_idx == 4'd11);

    // Fixed cube topology: vertex index bits are {z, y, x}, so each edge
    // joins two vertices differing in exactly one bit. Returns {a, b}.
    function automatic logic [5:0] edge_ends(input logic [3:0] idx);
        case (idx)
            4'd0:    return {3'd0, 3'd1};
            4'd1:    return {3'd2, 3'd3};
            4'd2:    return {3'd4, 3'd5};
            4'd3:    return {3'd6, 3'd7};
            4'd4:    return {3'd0, 3'd2};
            4'd5:    return {3'd1, 3'd3};
            4'd6:    return {3'd4, 3'd6};
            4'd7:    return {3'd5, 3'd7};
            4'd8:    return {3'd0, 3'd4};
            4'd9:    return {3'd1, 3'd5};
            4'd10:   return {3'd2, 3'd6};
            4'd11:   return {3'd3, 3'd7};
            default: return 6'd0;
        endcase
    endfunction

    assign {vert_a, vert_b} = edge_ends(edge_idx);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every register samples pre-edge
        // values regardless of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one edge per SETUP/START/WAIT/NEXT loop.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            S_IDLE:  if (go) state_next = S_SETUP;
            S_SETUP: state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (line_done) state_next = S_NEXT;
            S_NEXT:  state_next = last_edge ? S_DONE : S_SETUP;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        line_start = (state == S_START);
        frame_done = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    // Edge counter and endpoint registers; endpoints only move in SETUP so
    // draw_line sees stable coordinates for the whole WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_idx <= 4'd0;
            x0       <= '0;
            y0       <= '0;
            x1       <= '0;
            y1       <= '0;
        end else begin
            if (accept) begin
                edge_idx <= 4'd0;
            end else if (state == S_NEXT && !last_edge) begin
                edge_idx <= edge_idx + 4'd1;
            end
            if (state == S_SETUP) begin
                x0 <= act_x[vert_a];
                y0 <= act_y[vert_a];
                x1 <= act_x[vert_b];
                y1 <= act_y[vert_b];
            end
        end
    end

    // NOTE: the vertex banks are flops, not RAM, and are cleared on reset
    // so a frame started straight after reset renders a defined (zero) cube.
`ifdef CUBE_EDGE_SHADOW_EN
    logic [XY_BITW-1:0] shd_x      [8];
    logic [XY_BITW-1:0] shd_y      [8];
    logic [XY_BITW-1:0] shd_x_next [8];
    logic [XY_BITW-1:0] shd_y_next [8];

    // Shadow bank with this cycle's write folded in, so a write coincident
    // with go is part of the copy into the active bank.
    always_comb begin
        shd_x_next = shd_x;
        shd_y_next = shd_y;
        if (v_we) begin
            shd_x_next[v_addr] = v_x;
            shd_y_next[v_addr] = v_y;
        end
    end

    // Shadow takes every write; active bank snapshots it on go acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shd_x[i] <= '0;
                shd_y[i] <= '0;
                act_x[i] <= '0;
                act_y[i] <= '0;
            end
        end else begin
            shd_x <= shd_x_next;
            shd_y <= shd_y_next;
            if (accept) begin
                act_x <= shd_x_next;
                act_y <= shd_y_next;
            end
        end
    end
`else
    // Single bank: writes land only while idle, so a frame never sees a
    // half-updated cube; a write alongside go is visible to the first SETUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                act_x[i] <= '0;
                act_y[i] <= '0;
            end
        end else if (v_we && state == S_IDLE) begin
            act_x[v_addr] <= v_x;
            act_y[v_addr] <= v_y;
        end
    end
`endif

endmodule

// File: doc/cube_edge_seq.md
Name: cube_edge_seq

Overview:
- Upstream feeder for the line rasteriser (draw_line) in the vga_cube pipeline.
- Holds 8 projected cube vertices and walks a fixed 12-edge cube topology.
- For each edge it presents endpoint coordinates, pulses the rasteriser start, and waits for its done before moving on.
- One go request renders one full wireframe frame.

Parameters:
- XY_BITW, 16, width of every x/y coordinate; must match draw_line XY_BITW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- go  in  1  request a frame; accepted only in IDLE
- v_we  in  1  vertex write enable
- v_addr  in  3  vertex index, bit2=z, bit1=y, bit0=x corner
- v_x  in  XY_BITW  vertex x write data
- v_y  in  XY_BITW  vertex y write data
- line_done  in  1  done pulse from draw_line
- line_start  out  1  one-cycle start pulse to draw_line
- x0, y0, x1, y1  out  XY_BITW each  current edge endpoints
- edge_idx  out  4  index of current edge, 0..11
- busy  out  1  high from go acceptance until frame_done inclusive
- frame_done  out  1  one-cycle pulse after edge 11 completes

Behaviour:
- Reset: state IDLE; line_start=0, busy=0, frame_done=0, edge_idx=0, x0/y0/x1/y1=0; all vertex registers=0.
- Edge ROM, index: (a,b)
  - x-direction: 0:(0,1) 1:(2,3) 2:(4,5) 3:(6,7)
  - y-direction: 4:(0,2) 5:(1,3) 6:(4,6) 7:(5,7)
  - z-direction: 8:(0,4) 9:(1,5) 10:(2,6) 11:(3,7)
  - Endpoint 0 = vertex a, endpoint 1 = vertex b.
- FSM states: IDLE, SETUP, START, WAIT, NEXT, DONE.
  - IDLE: if go, clear edge_idx to 0 and go to SETUP; busy rises the same cycle.
  - SETUP: register x0,y0 from vertex a and x1,y1 from vertex b for the current edge_idx; go to START.
  - START: line_start=1 for exactly this cycle; go to WAIT.
  - WAIT: hold everything; on line_done=1 go to NEXT.
  - NEXT: if edge_idx==11 go to DONE, else edge_idx+1 and go to SETUP.
  - DONE: frame_done=1 for one cycle; go to IDLE; busy falls on entering IDLE.
- Latency:
  - go sampled at edge N gives line_start high in cycle N+2.
  - line_done at edge M gives the next line_start in cycle M+3.
- x0..y1 and edge_idx are stable from the end of SETUP until the next SETUP, including all of WAIT.
- line_done outside WAIT is ignored; it is not queued.
- go while busy is ignored; no queued request.
- go coincident with reset: reset wins.
- Degenerate edge (a and b equal in coordinate value) is still issued and waited on; draw_line handles it.
- Reset mid-frame: synchronous return to IDLE with reset values; an in-flight draw_line is not notified.
- Vertex writes without the optional feature:
  - Write to the active vertex registers on v_we, only while not busy.
  - v_we while busy is dropped.
  - Write and go in the same IDLE cycle: the write takes effect; SETUP sees the new value.
- No arithmetic beyond the edge counter; the counter never exceeds 11.

Optional Feature:
- Macro: CUBE_EDGE_SHADOW_EN.
- Defined:
  - A second (shadow) 8-vertex bank is added.
  - v_we writes the shadow bank at any time, including while busy.
  - On go acceptance, all 8 shadow entries are copied into the active bank in the same cycle.
  - A write in that same cycle lands in shadow and is included in the copy.
  - The frame always renders one coherent vertex set.
- Undefined: single bank only, with the busy-drop rule above.

Test Plan:
- Reset, then write vertex k = (10k, 5k) for k=0..7. Pulse go; model draw_line as line_done 3 cycles after each line_start. Required: 12 line_start pulses. Edge 0 = (0,0)-(10,5); edge 4 = (0,0)-(20,10); edge 11 = (30,15)-(70,35). Then one frame_done; busy low the following cycle.
- Pulse go at cycle 5. Required: line_start exactly at cycle 7. With line_done at cycle 20, the next line_start is at cycle 23 and edge_idx=1.
- Pulse go again and hold line_done during START, during WAIT, and at edge 3. Required: go ignored and no second frame. Stray line_done outside WAIT ignored; edge_idx does not skip.
- Assert rst during WAIT of edge 6. Required: next cycle busy=0, edge_idx=0, line_start=0, x0..y1=0. A subsequent go restarts from edge 0 with vertices zeroed.
- While busy, write vertex 1 = (99,99), then let the frame finish and pulse go again.
  - Without CUBE_EDGE_SHADOW_EN: the write is dropped; frame 2 edge 0 = (0,0)-(10,5).
  - With it: frame 1 is unchanged; frame 2 edge 0 = (0,0)-(99,99).
- Write vertex 3 = (7,8) and pulse go in the same IDLE cycle. Required: edge 1 = (20,10)-(7,8) in both macro configurations.
